// File: rtl/csr_file_pkg.sv
// csr_file_pkg -- shared definitions for the CSR file.
//   CSR address constants (14-bit CSR numbers), field bit positions,
//   the CRMD reset value and the masked-write merge helper.
package csr_file_pkg;

  localparam int CSR_NUM_W = 14;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // CRMD / PRMD fields
  localparam int CRMD_IE = 2;
  localparam int CRMD_DA = 3;
  localparam int PRMD_PIE = 2;

  // ESTAT fields
  localparam int ESTAT_ECODE_LO = 16;
  localparam int ESTAT_ESUB_LO  = 22;
  localparam int IS_TIMER       = 11;

  // TCFG fields
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  localparam logic [4:0]  CRMD_RESET    = 5'b01000;  // DA=1, PLV=0, IE=0
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;  // LIE bit 10 is reserved

  // Bitwise masked update of a CSR image.
  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] wvalue,
                                            input logic [31:0] wmask);
    return (old_v & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// csr_timer -- TCFG/TVAL countdown timer and the timer interrupt bit IS[11].
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   tcfg_we         write TCFG with wr_data (also reloads TVAL)
//   ticlr_we        TICLR write; wr_data[0]=1 clears the interrupt
//   wr_data         already mask-merged write data
//   tcfg, tval      current register values for readback
//   timer_is        ESTAT.IS[11]
module csr_timer
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  logic        ticlr_we,
  input  logic [31:0] wr_data,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        timer_is
);

  logic [31:0] tcfg_reg;
  logic [31:0] tval_reg;
  logic        timer_is_reg;
  logic        hit_zero;

  // A 1->0 step only happens when the counter actually decrements this cycle.
  assign hit_zero = tcfg_reg[TCFG_EN] && !tcfg_we && (tval_reg == 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg_reg     <= 32'h0;
      tval_reg     <= 32'h0;
      timer_is_reg <= 1'b0;
    end else begin
      if (tcfg_we) begin
        tcfg_reg <= wr_data;
        tval_reg <= {wr_data[31:2], 2'b00};
      end else if (tcfg_reg[TCFG_EN]) begin
        if (tval_reg != 32'h0)
          tval_reg <= tval_reg - 32'd1;
        else if (tcfg_reg[TCFG_PERIODIC])
          tval_reg <= {tcfg_reg[31:2], 2'b00};
      end
      // Set beats a simultaneous clear so no tick is lost.
      if (hit_zero)
        timer_is_reg <= 1'b1;
      else if (ticlr_we && wr_data[0])
        timer_is_reg <= 1'b0;
    end
  end

  assign tcfg     = tcfg_reg;
  assign tval     = tval_reg;
  assign timer_is = timer_is_reg;

endmodule

// File: rtl/csr_file.sv
// csr_file -- exception/interrupt control-and-status register file.
// Optional timer (TID/TCFG/TVAL/TICLR) is built when CSR_TIMER_EN is defined.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   csr_re, csr_num, csr_rvalue    combinational read port
//   csr_we, csr_wmask, csr_wvalue  masked write port
//   wb_ex, wb_ecode, wb_esubcode, wb_ex_pc   exception commit
//   ertn_flush                     exception return commit
//   hw_int_in                      level hardware interrupt lines
//   ex_entry, era_out              redirect targets
//   has_int                        pending enabled interrupt
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] COREID = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_ex_pc,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] era_out,
  output logic        has_int
);

  logic [4:0]  crmd_reg;
  logic [2:0]  prmd_reg;
  logic [12:0] lie_reg;
  logic [1:0]  is_sw_reg;
  logic [7:0]  is_hw_reg;
  logic [5:0]  ecode_reg;
  logic [8:0]  esubcode_reg;
  logic [31:0] era_reg;
  logic [25:0] eentry_reg;
  logic [31:0] save_q [4];
  logic [12:0] estat_is;
  logic        timer_is;
  logic [31:0] rd_data;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        unused_re;

  // Reads never depend on csr_re; it is accepted for interface compatibility.
  assign unused_re = csr_re;

  // Exceptions and ertn swallow any CSR write committed in the same cycle.
  assign wr_en = csr_we && !wb_ex && !ertn_flush;

  // Merging against the readback image gives the new value of every field
  // of the addressed CSR; each register then keeps its writable slice.
  assign wr_data = csr_merge(rd_data, csr_wvalue, csr_wmask);

`ifdef CSR_TIMER_EN
  logic [31:0] tid_reg;
  logic [31:0] tcfg;
  logic [31:0] tval;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tid_reg <= COREID;
    else if (wr_en && csr_num == CSR_TID)
      tid_reg <= wr_data;
  end

  csr_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .tcfg_we  (wr_en && csr_num == CSR_TCFG),
    .ticlr_we (wr_en && csr_num == CSR_TICLR),
    .wr_data  (wr_data),
    .tcfg     (tcfg),
    .tval     (tval),
    .timer_is (timer_is)
  );
`else
  logic unused_coreid;
  assign unused_coreid = ^COREID;
  assign timer_is      = 1'b0;
`endif

  assign estat_is = {1'b0, timer_is, 1'b0, is_hw_reg, is_sw_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_reg     <= CRMD_RESET;
      prmd_reg     <= 3'h0;
      lie_reg      <= 13'h0;
      is_sw_reg    <= 2'h0;
      is_hw_reg    <= 8'h0;
      ecode_reg    <= 6'h0;
      esubcode_reg <= 9'h0;
      era_reg      <= 32'h0;
      eentry_reg   <= 26'h0;
    end else begin
      is_hw_reg <= hw_int_in;
      if (wb_ex) begin
        prmd_reg      <= crmd_reg[2:0];  // {IE, PLV} -> {PIE, PPLV}
        crmd_reg[2:0] <= 3'h0;
        ecode_reg     <= wb_ecode;
        esubcode_reg  <= wb_esubcode;
        era_reg       <= wb_ex_pc;
      end else if (ertn_flush) begin
        crmd_reg[2:0] <= prmd_reg;
      end else if (wr_en) begin
        case (csr_num)
          CSR_CRMD:   crmd_reg   <= wr_data[4:0];
          CSR_PRMD:   prmd_reg   <= wr_data[2:0];
          CSR_ECFG:   lie_reg    <= wr_data[12:0] & ECFG_LIE_MASK;
          CSR_ESTAT:  is_sw_reg  <= wr_data[1:0];
          CSR_ERA:    era_reg    <= wr_data;
          CSR_EENTRY: eentry_reg <= wr_data[31:6];
          default: ;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_save
      localparam logic [13:0] SAVE_NUM = CSR_SAVE0 + 14'(gi);
      logic [31:0] save_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          save_reg <= 32'h0;
        else if (wr_en && csr_num == SAVE_NUM)
          save_reg <= wr_data;
      end
      assign save_q[gi] = save_reg;
    end
  endgenerate

  always_comb begin
    rd_data = 32'h0;
    case (csr_num)
      CSR_CRMD:   rd_data = {27'h0, crmd_reg};
      CSR_PRMD:   rd_data = {29'h0, prmd_reg};
      CSR_ECFG:   rd_data = {19'h0, lie_reg};
      CSR_ESTAT:  rd_data = {1'b0, esubcode_reg, ecode_reg, 3'h0, estat_is};
      CSR_ERA:    rd_data = era_reg;
      CSR_EENTRY: rd_data = {eentry_reg, 6'h0};
      CSR_SAVE0:  rd_data = save_q[0];
      CSR_SAVE1:  rd_data = save_q[1];
      CSR_SAVE2:  rd_data = save_q[2];
      CSR_SAVE3:  rd_data = save_q[3];
`ifdef CSR_TIMER_EN
      CSR_TID:    rd_data = tid_reg;
      CSR_TCFG:   rd_data = tcfg;
      CSR_TVAL:   rd_data = tval;
`endif
      default:    rd_data = 32'h0;
    endcase
  end

  assign csr_rvalue = rd_data;
  assign ex_entry   = {eentry_reg, 6'h0};
  assign era_out    = era_reg;
  assign has_int    = crmd_reg[CRMD_IE] & (|(estat_is & lie_reg));

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  localparam logic [31:0] TB_COREID = 32'h1234_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_re = 1'b0;
  logic [13:0] csr_num = 14'h0;
  logic [31:0] csr_rvalue;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wmask = 32'h0;
  logic [31:0] csr_wvalue = 32'h0;
  logic        wb_ex = 1'b0;
  logic [5:0]  wb_ecode = 6'h0;
  logic [8:0]  wb_esubcode = 9'h0;
  logic [31:0] wb_ex_pc = 32'h0;
  logic        ertn_flush = 1'b0;
  logic [7:0]  hw_int_in = 8'h0;
  logic [31:0] ex_entry;
  logic [31:0] era_out;
  logic        has_int;

  csr_file #(.COREID(TB_COREID)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_ex_pc    (wb_ex_pc),
    .ertn_flush  (ertn_flush),
    .hw_int_in   (hw_int_in),
    .ex_entry    (ex_entry),
    .era_out     (era_out),
    .has_int     (has_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the expectation pushed when the stimulus was issued and compare.
  task automatic score(input string name, input logic [31:0] got);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, got, e);
    end else begin
      $display("ok   %s: %08h", name, got);
    end
  endtask

  task automatic rd(input string name, input logic [13:0] num,
                    input logic [31:0] mask, input logic [31:0] exp);
    csr_num = num;
    exp_q.push_back(exp & mask);
    #1;
    score(name, csr_rvalue & mask);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    exp_q.push_back(exp);
    score(name, got);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    tick();
    csr_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{14'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_001F};
    vecs[1]  = '{14'h000, 32'h0000_0003, 32'h0000_0000, 32'h0000_001C};
    vecs[2]  = '{14'h001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
    vecs[3]  = '{14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
    vecs[4]  = '{14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[5]  = '{14'h006, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    vecs[6]  = '{14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
    vecs[7]  = '{14'h030, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[8]  = '{14'h031, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[9]  = '{14'h032, 32'h0000_FFFF, 32'hAAAA_5555, 32'h0000_5555};
    vecs[10] = '{14'h033, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[11] = '{14'h007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[13] = '{14'h006, 32'h0000_FF00, 32'h0000_0000, 32'h1234_0078};
    vecs[14] = '{14'h044, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state
    #12;
    rd("rst_crmd_in_reset", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    chk("rst_has_int", {31'h0, has_int}, 32'h0);
    tick();
    reset = 1'b0;
    rd("rst_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    rd("rst_unmapped_7", 14'h007, 32'hFFFF_FFFF, 32'h0);
    rd("rst_save0", 14'h030, 32'hFFFF_FFFF, 32'h0);
`ifdef CSR_TIMER_EN
    rd("rst_tid", 14'h040, 32'hFFFF_FFFF, TB_COREID);
    rd("rst_tval", 14'h042, 32'hFFFF_FFFF, 32'h0);
`endif

    // Masked write/readback table
    for (int i = 0; i < 15; i++) begin
      wr(vecs[i].num, vecs[i].wmask, vecs[i].wvalue);
      rd($sformatf("vec%0d_num%03h", i, vecs[i].num), vecs[i].num, 32'hFFFF_FFFF, vecs[i].exp);
    end
    chk("ex_entry", ex_entry, 32'hFFFF_FFC0);
    chk("era_out_masked", era_out, 32'h1234_0078);
    chk("has_int_sw", {31'h0, has_int}, 32'h1);

    // Exception commit
    wr(14'h000, 32'hFFFF_FFFF, 32'h7);
    wb_ex = 1'b1; wb_ecode = 6'hB; wb_esubcode = 9'h0; wb_ex_pc = 32'h1C00_0100;
    tick();
    wb_ex = 1'b0;
    rd("ex_prmd", 14'h001, 32'hFFFF_FFFF, 32'h7);
    rd("ex_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0);
    rd("ex_estat", 14'h005, 32'hFFFF_FFFF, 32'h000B_0003);
    chk("ex_era_out", era_out, 32'h1C00_0100);
    chk("ex_has_int_masked", {31'h0, has_int}, 32'h0);

    // Exception return
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    rd("ertn_crmd", 14'h000, 32'hFFFF_FFFF, 32'h7);
    chk("ertn_has_int", {31'h0, has_int}, 32'h1);

    // wb_ex beats a same-cycle SAVE0 write
    wb_ex = 1'b1; wb_ecode = 6'h3F; wb_esubcode = 9'h1FF; wb_ex_pc = 32'h8000_0004;
    csr_we = 1'b1; csr_num = 14'h030; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h1111_1111;
    tick();
    wb_ex = 1'b0; csr_we = 1'b0;
    rd("exwe_save0", 14'h030, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    rd("exwe_estat", 14'h005, 32'hFFFF_FFFF, 32'h7FFF_0003);
    chk("exwe_era", era_out, 32'h8000_0004);

    // ertn beats a same-cycle SAVE1 write
    ertn_flush = 1'b1;
    csr_we = 1'b1; csr_num = 14'h031; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h2222_2222;
    tick();
    ertn_flush = 1'b0; csr_we = 1'b0;
    rd("ertnwe_save1", 14'h031, 32'hFFFF_FFFF, 32'h1);
    rd("ertnwe_crmd", 14'h000, 32'hFFFF_FFFF, 32'h7);

    // wb_ex beats a same-cycle ertn
    wb_ex = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h1; wb_esubcode = 9'h2; wb_ex_pc = 32'h1C00_0200;
    tick();
    wb_ex = 1'b0; ertn_flush = 1'b0;
    rd("exertn_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0);
    chk("exertn_era", era_out, 32'h1C00_0200);
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;

    // Hardware interrupt sampling and has_int masking
    hw_int_in = 8'hA5;
    tick();
    rd("hw_estat", 14'h005, 32'hFFFF_FFFF, 32'h0081_0297);
    wr(14'h004, 32'hFFFF_FFFF, 32'h0);
    wr(14'h005, 32'h0000_0003, 32'h0);
    chk("hw_lie_off", {31'h0, has_int}, 32'h0);
    wr(14'h004, 32'hFFFF_FFFF, 32'h4);
    chk("hw_lie2_on", {31'h0, has_int}, 32'h1);
    hw_int_in = 8'h00;
    tick();
    chk("hw_released", {31'h0, has_int}, 32'h0);

`ifdef CSR_TIMER_EN
    wr(14'h040, 32'hFFFF_FFFF, 32'h0000_55AA);
    rd("tid_write", 14'h040, 32'hFFFF_FFFF, 32'h0000_55AA);
    wr(14'h004, 32'hFFFF_FFFF, 32'h800);
    wr(14'h042, 32'hFFFF_FFFF, 32'h1234_5678);
    rd("tval_readonly", 14'h042, 32'hFFFF_FFFF, 32'h0);

    // One-shot countdown
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0013);
    rd("tcfg_oneshot", 14'h041, 32'hFFFF_FFFF, 32'h13);
    rd("tval_load", 14'h042, 32'hFFFF_FFFF, 32'h10);
    for (int i = 15; i >= 0; i--) begin
      tick();
      rd($sformatf("tval_cnt%0d", i), 14'h042, 32'hFFFF_FFFF, 32'(i));
      if (i == 1) rd("is11_before_zero", 14'h005, 32'h800, 32'h0);
    end
    rd("is11_at_zero", 14'h005, 32'h800, 32'h800);
    chk("timer_has_int", {31'h0, has_int}, 32'h1);
    tick(); tick(); tick();
    rd("tval_hold0", 14'h042, 32'hFFFF_FFFF, 32'h0);
    wr(14'h044, 32'h1, 32'h1);
    rd("ticlr_is11", 14'h005, 32'h800, 32'h0);
    chk("ticlr_has_int", {31'h0, has_int}, 32'h0);

    // Periodic mode
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0017);
    rd("per_load", 14'h042, 32'hFFFF_FFFF, 32'h10);
    repeat (16) tick();
    rd("per_zero", 14'h042, 32'hFFFF_FFFF, 32'h0);
    rd("per_is11_set", 14'h005, 32'h800, 32'h800);
    tick();
    rd("per_reload", 14'h042, 32'hFFFF_FFFF, 32'h10);
    wr(14'h044, 32'h1, 32'h1);
    rd("per_ticlr", 14'h005, 32'h800, 32'h0);
    rd("per_after_clr", 14'h042, 32'hFFFF_FFFF, 32'hF);

    // Clear coinciding with the 1->0 step: set must win
    begin
      logic found;
      found = 1'b0;
      csr_num = 14'h042;
      #1;
      for (int k = 0; k < 40 && !found; k++) begin
        if (csr_rvalue == 32'h1) found = 1'b1;
        else tick();
      end
      chk("per_reach_one", {31'h0, found}, 32'h1);
    end
    wr(14'h044, 32'h1, 32'h1);
    rd("setwins_tval", 14'h042, 32'hFFFF_FFFF, 32'h0);
    rd("setwins_is11", 14'h005, 32'h800, 32'h800);

    // Start a countdown that reset will abort
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0013);
    tick(); tick(); tick();
`else
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0013);
    rd("notimer_tid", 14'h040, 32'hFFFF_FFFF, 32'h0);
    rd("notimer_tcfg", 14'h041, 32'hFFFF_FFFF, 32'h0);
    rd("notimer_tval", 14'h042, 32'hFFFF_FFFF, 32'h0);
    rd("notimer_ticlr", 14'h044, 32'hFFFF_FFFF, 32'h0);
    repeat (20) tick();
    rd("notimer_is11", 14'h005, 32'h800, 32'h0);
`endif

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    rd("areset_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    rd("areset_save0", 14'h030, 32'hFFFF_FFFF, 32'h0);
    rd("areset_estat", 14'h005, 32'hFFFF_FFFF, 32'h0);
    chk("areset_has_int", {31'h0, has_int}, 32'h0);
`ifdef CSR_TIMER_EN
    rd("areset_tval", 14'h042, 32'hFFFF_FFFF, 32'h0);
    rd("areset_tcfg", 14'h041, 32'hFFFF_FFFF, 32'h0);
    rd("areset_tid", 14'h040, 32'hFFFF_FFFF, TB_COREID);
`endif
    tick();
    reset = 1'b0;
    repeat (5) tick();
`ifdef CSR_TIMER_EN
    rd("post_reset_tval", 14'h042, 32'hFFFF_FFFF, 32'h0);
`endif
    rd("post_reset_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
